// File: rtl/pipelined_adder_pkg.sv
// Shared constants, helpers and the elaboration-time geometry check for pipelined_adder.
`ifndef PIPELINED_ADDER_PKG_SV
`define PIPELINED_ADDER_PKG_SV

package pipelined_adder_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// Rejects a slice geometry that cannot tile the operand width evenly.
`define PA_CHECK_WIDTH(W, S) \
    if ((S) == 0 || (S) > (W) || ((W) % (S)) != 0) begin : g_width_check \
        $error("pipelined_adder: WIDTH must be a positive multiple of STAGES"); \
    end

`endif

// File: rtl/adder_slice.sv
// One CHUNK-bit slice of the carry chain; also exposes the slice operand MSBs for overflow.
module adder_slice #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             a_msb_o,
    output logic             b_msb_o
);

    always_comb begin
        {cout_o, sum_o} = (CHUNK + 1)'(a_i) + (CHUNK + 1)'(b_i) + (CHUNK + 1)'(cin_i);
    end

    assign a_msb_o = a_i[CHUNK-1];
    assign b_msb_o = b_i[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// Adder/subtractor with the carry chain cut into STAGES registered slices and a global-stall handshake.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned NREG  = (STAGES > 1) ? STAGES - 1 : 1;

    `PA_CHECK_WIDTH(WIDTH, STAGES)

    logic             adv;

    // Per-stage sources: stage 0 takes the ports, stage k takes the registers of stage k-1.
    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] s_src [STAGES];
    logic             c_src [STAGES];
    logic             v_src [STAGES];
    logic [WIDTH-1:0] s_d   [STAGES];

    logic [CHUNK-1:0] slice_sum  [STAGES];
    logic             slice_cout [STAGES];
    logic             a_msb      [STAGES];
    logic             b_msb      [STAGES];

    logic [WIDTH-1:0] a_q [NREG];
    logic [WIDTH-1:0] b_q [NREG];
    logic [WIDTH-1:0] s_q [NREG];
    logic             c_q [NREG];
    logic             v_q [NREG];

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             ovf_d;

    assign adv = !out_valid_q || out_ready;

    always_comb begin
        a_src[0] = a;
        b_src[0] = (sub == SUB) ? ~b : b;
        c_src[0] = (sub == ADD) ? cin : 1'b1;
        s_src[0] = '0;
        v_src[0] = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            s_src[k] = s_q[k-1];
            c_src[k] = c_q[k-1];
            v_src[k] = v_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .a_i     (a_src[k][k*CHUNK +: CHUNK]),
            .b_i     (b_src[k][k*CHUNK +: CHUNK]),
            .cin_i   (c_src[k]),
            .sum_o   (slice_sum[k]),
            .cout_o  (slice_cout[k]),
            .a_msb_o (a_msb[k]),
            .b_msb_o (b_msb[k])
        );
    end

    // Merge each stage's fresh slice into the partial result carried from earlier stages.
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            s_d[k]                     = s_src[k];
            s_d[k][k*CHUNK +: CHUNK]   = slice_sum[k];
        end
    end

    assign ovf_d = (a_msb[STAGES-1] == b_msb[STAGES-1]) &&
                   (s_d[STAGES-1][WIDTH-1] != a_msb[STAGES-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NREG; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv) begin
            for (int unsigned k = 0; k + 1 < STAGES; k++) begin
                a_q[k] <= a_src[k];
                b_q[k] <= b_src[k];
                s_q[k] <= s_d[k];
                c_q[k] <= slice_cout[k];
                v_q[k] <= v_src[k];
            end
            out_valid_q <= v_src[STAGES-1];
            sum_q       <= s_d[STAGES-1];
            cout_q      <= slice_cout[STAGES-1];
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder (WIDTH=8, STAGES=2): directed cases plus randomized traffic against an arithmetic model.
module tb_pipelined_adder;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 2;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q [$];
    logic [7:0] emitted [$];

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference: {ovf, cout, sum}
    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic mc, input logic ms);
        int ua, ub, sa, sb, ur, sr;
        logic co, ov;
        ua = int'(ma);
        ub = int'(mb);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        if (ms) begin
            ur = ua - ub;
            sr = sa - sb;
            co = (ua >= ub);
        end else begin
            ur = ua + ub + int'(mc);
            sr = sa + sb + int'(mc);
            co = (ur > 255);
        end
        ov = (sr > 127) || (sr < -128);
        return {ov, co, 8'(ur & 255)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    // Account for transfers at the coming edge, advance one cycle, then verify stall hold.
    task automatic tick();
        logic       stalled;
        logic [7:0] ps;
        logic       pc, po;
        logic [9:0] e;
        #1;
        stalled = rst_n && out_valid && !out_ready;
        ps = sum;
        pc = cout;
        po = ovf;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                emitted.push_back(sum);
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_sum", 32'(sum), 32'(e[7:0]));
                    check("sb_cout", 32'(cout), 32'(e[8]));
                    check("sb_ovf", 32'(ovf), 32'(e[9]));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (stalled) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_sum", 32'(sum), 32'(ps));
            check("stall_cout", 32'(cout), 32'(pc));
            check("stall_ovf", 32'(ovf), 32'(po));
        end
    endtask

    task automatic send(input string tag, input logic [7:0] ta, input logic [7:0] tbv,
                        input logic tc, input logic ts,
                        input logic [7:0] es, input logic ec, input logic eo);
        a         = ta;
        b         = tbv;
        cin       = tc;
        sub       = ts;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"}, 32'(sum), 32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        send("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        send("add_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        send("sub_borrow", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        tick();

        // Four back-to-back adds with a 3-cycle downstream stall mid-stream
        emitted.delete();
        sub = 1'b0; cin = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        a = 8'd1; b = 8'd1; tick();
        a = 8'd2; b = 8'd2; tick();
        check("stream_first_valid", 32'(out_valid), 32'd1);
        a = 8'd3; b = 8'd3; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stream_stall_in_ready", 32'(in_ready), 32'd0);
            check("stream_stall_sum", 32'(sum), 32'd2);
            tick();
        end
        out_ready = 1'b1;
        tick();
        a = 8'd4; b = 8'd4; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("stream_count", 32'(emitted.size()), 32'd4);
        if (emitted.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("stream_order", 32'(emitted[i]), 32'(2 * (i + 1)));
            end
        end

        // Reset with two beats in flight
        out_ready = 1'b0; in_valid = 1'b1;
        a = 8'd5; b = 8'd6; tick();
        a = 8'd7; b = 8'd8; tick();
        check("flight_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        check("midrst_ovf", 32'(ovf), 32'd0);
        send("post_rst", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);
        tick();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
